// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative instruction cache, round-robin victims; ICACHE_STATS_EN adds hit/miss counters
module icache_assoc #(
  parameter int DATABITWIDTH = 16,
  parameter int ADDRESSWIDTH = 10,
  parameter int SETS = 4,
  parameter int WAYS = 2,
  parameter int LINESIZE = 8
) (
  input  logic clk,
  input  logic sync_rst,
  input  logic clk_en,
  input  logic req,
  input  logic [ADDRESSWIDTH-1:0] address_in,
  input  logic invalidate,
  input  logic [ADDRESSWIDTH-1:0] invalidate_address,
  output logic [DATABITWIDTH-1:0] data_out,
  output logic busy,
`ifdef ICACHE_STATS_EN
  output logic [15:0] hit_count,
  output logic [15:0] miss_count,
`endif
  output logic mem_req,
  output logic [ADDRESSWIDTH-1:0] mem_address,
  input  logic [DATABITWIDTH-1:0] mem_data,
  input  logic mem_valid
);
  localparam int OB = $clog2(LINESIZE);
  localparam int IB = $clog2(SETS);
  localparam int TW = ADDRESSWIDTH - OB - IB;
  localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  logic [1:0] state;
  logic [ADDRESSWIDTH-1:0] addr_r;
  logic pending, stale, from_ptr, from_ptr_n;
  logic [WAYS-1:0] hit_r, hit_n;
  logic [WW-1:0] victim, victim_n, hit_way;
  logic [WW-1:0] rr [SETS];
  logic [WAYS-1:0] valid [SETS];
  logic [TW-1:0] tags [WAYS][SETS];
  logic [DATABITWIDTH-1:0] lines [WAYS][SETS*LINESIZE];
  logic [OB-1:0] ptr, a_off;
  logic [IB-1:0] a_idx, i_idx, in_idx;
  logic [TW-1:0] a_tag, i_tag, in_tag;
  logic [DATABITWIDTH-1:0] out_q, hit_word, req_word;
  logic hit_now, start, inv_line;
  assign a_off = addr_r[OB-1:0];
  assign a_idx = addr_r[OB +: IB];
  assign a_tag = addr_r[OB+IB +: TW];
  assign i_idx = invalidate_address[OB +: IB];
  assign i_tag = invalidate_address[OB+IB +: TW];
  assign in_idx = address_in[OB +: IB];
  assign in_tag = address_in[OB+IB +: TW];
  assign hit_now = pending && state == IDLE && |hit_r;
  assign start = pending && state == IDLE && !(|hit_r);
  assign busy = pending && (state != IDLE || !(|hit_r));
  assign inv_line = invalidate && i_idx == a_idx && i_tag == a_tag;
  assign hit_word = lines[hit_way][{a_idx, a_off}];
  assign req_word = lines[victim][{a_idx, a_off}];
  assign data_out = hit_now ? hit_word : out_q;
  assign mem_req = state == FILL;
  assign mem_address = mem_req ? {a_tag, a_idx, ptr} : '0;
  // tag compare for the incoming request, captured at acceptance
  always_comb begin
    hit_n = '0;
    for (int w = 0; w < WAYS; w++) hit_n[w] = valid[in_idx][w] && tags[w][in_idx] == in_tag;
  end
  // one-hot hit vector to way number
  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) if (hit_r[w]) hit_way = WW'(w);
  end
  // victim: lowest invalid way, otherwise the set's round-robin pointer
  always_comb begin
    victim_n = rr[a_idx];
    from_ptr_n = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) if (!valid[a_idx][w]) begin
      victim_n = WW'(w);
      from_ptr_n = 1'b0;
    end
  end
  // request acceptance, fill FSM, invalidation and replacement state
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state <= IDLE;
      pending <= 1'b0;
      stale <= 1'b0;
      from_ptr <= 1'b0;
      ptr <= '0;
      out_q <= '0;
      addr_r <= '0;
      hit_r <= '0;
      victim <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        rr[s] <= '0;
      end
    end else if (clk_en) begin
      if (req && !busy) begin
        addr_r <= address_in;
        hit_r <= hit_n;
        pending <= 1'b1;
      end else if (hit_now || state == COMMIT) pending <= 1'b0;
      if (hit_now) out_q <= hit_word;
      if (invalidate) for (int w = 0; w < WAYS; w++) if (tags[w][i_idx] == i_tag) valid[i_idx][w] <= 1'b0;
      if (inv_line && (state == FILL || start)) stale <= 1'b1;
      if (start) begin
        state <= FILL;
        victim <= victim_n;
        from_ptr <= from_ptr_n;
        ptr <= '0;
      end
      if (state == FILL && mem_valid) begin
        ptr <= ptr + 1'b1;
        if (&ptr) state <= COMMIT;
      end
      if (state == COMMIT) begin
        tags[victim][a_idx] <= a_tag;
        valid[a_idx][victim] <= !(stale || inv_line);
        if (WAYS > 1 && from_ptr) rr[a_idx] <= rr[a_idx] + 1'b1;
        out_q <= req_word;
        stale <= 1'b0;
        state <= IDLE;
      end
    end
  end
  // line fill data writes
  always_ff @(posedge clk) begin
    if (!sync_rst && clk_en && state == FILL && mem_valid) lines[victim][{a_idx, ptr}] <= mem_data;
  end
`ifdef ICACHE_STATS_EN
  // saturating hit/miss counters
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      hit_count <= '0;
      miss_count <= '0;
    end else if (clk_en) begin
      if (hit_now && !(&hit_count)) hit_count <= hit_count + 1'b1;
      if (start && !(&miss_count)) miss_count <= miss_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed self-checking bench for icache_assoc (memory returns address + 0x100)
module tb_icache_assoc;
  logic clk = 1'b0;
  logic sync_rst, clk_en, req, invalidate, mem_valid, busy, mem_req;
  logic [9:0] address_in, invalidate_address, mem_address;
  logic [15:0] data_out, mem_data;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  int exp_hits = 0;
  int exp_miss = 0;
  int vcnt = 0;
  bit thr = 1'b0;
  logic [9:0] log_q [$];
  icache_assoc dut (
    .clk(clk),
    .sync_rst(sync_rst),
    .clk_en(clk_en),
    .req(req),
    .address_in(address_in),
    .invalidate(invalidate),
    .invalidate_address(invalidate_address),
    .data_out(data_out),
    .busy(busy),
`ifdef ICACHE_STATS_EN
    .hit_count(hit_count),
    .miss_count(miss_count),
`endif
    .mem_req(mem_req),
    .mem_address(mem_address),
    .mem_data(mem_data),
    .mem_valid(mem_valid)
  );
  always #5 clk = ~clk;
  assign mem_data = 16'(mem_address) + 16'h0100;
  initial forever begin
    @(negedge clk);
    vcnt++;
    mem_valid = thr ? (vcnt % 3 == 0) : 1'b1;
  end
  always @(posedge clk) if (!sync_rst && clk_en && mem_req && mem_valid) log_q.push_back(mem_address);
  always @(negedge clk) assert ($countones(dut.hit_r) <= 1) else $error("FAIL multi_hit: %0d ways hit, at most 1 allowed", $countones(dut.hit_r));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic inv(input logic [9:0] a);
    invalidate = 1'b1;
    invalidate_address = a;
    tick();
    invalidate = 1'b0;
  endtask
  task automatic chk_log(input string tag, input logic [9:0] base);
    chk({tag, "_n"}, log_q.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_%0d", tag, i), i < log_q.size() ? 32'(log_q[i]) : 32'hFFFF, 32'(base + 10'(i)));
  endtask
  task automatic fetch(input logic [9:0] a, input int exp_busy, input int ev_at, input int ev_kind, input logic [9:0] ev_addr, input string tag);
    int n = 0;
    int frz = 0;
    req = 1'b1;
    address_in = a;
    tick();
    req = 1'b0;
    while ((busy || frz > 0) && n < 100) begin
      if (n == ev_at && ev_kind == 1) begin
        invalidate = 1'b1;
        invalidate_address = ev_addr;
      end
      if (n == ev_at && ev_kind == 2) begin
        clk_en = 1'b0;
        frz = 5;
      end
      tick();
      n++;
      invalidate = 1'b0;
      if (frz > 0) begin
        chk({tag, "_frozen_addr"}, mem_address, ev_addr);
        frz--;
        if (frz == 0) clk_en = 1'b1;
      end
    end
    if (exp_busy >= 0) chk({tag, "_busy_cycles"}, n, exp_busy);
    chk({tag, "_done"}, busy, 0);
    chk({tag, "_data"}, data_out, 16'(a) + 16'h0100);
    if (exp_busy == 0) exp_hits++;
    else exp_miss++;
  endtask
  initial begin
    sync_rst = 1'b1;
    clk_en = 1'b1;
    req = 1'b0;
    invalidate = 1'b0;
    address_in = '0;
    invalidate_address = '0;
    tick();
    tick();
    sync_rst = 1'b0;
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_address, 0);
    log_q.delete();
    fetch(10'h00A, 10, -1, 0, 0, "cold");
    chk_log("cold_addr", 10'h008);
    fetch(10'h00C, 0, -1, 0, 0, "cold_hit");
    fetch(10'h000, 10, -1, 0, 0, "cf_000");
    fetch(10'h020, 10, -1, 0, 0, "cf_020");
    fetch(10'h040, 10, -1, 0, 0, "cf_040");
    fetch(10'h020, 0, -1, 0, 0, "cf_020_hit");
    fetch(10'h000, 10, -1, 0, 0, "cf_000_evicted");
    fetch(10'h040, 0, -1, 0, 0, "cf_040_hit");
    fetch(10'h020, 10, -1, 0, 0, "cf_020_evicted");
    thr = 1'b1;
    log_q.delete();
    fetch(10'h1F8, -1, -1, 0, 0, "thr");
    thr = 1'b0;
    chk_log("thr_addr", 10'h1F8);
    chk("thr_mem_req", mem_req, 0);
    fetch(10'h1FD, 0, -1, 0, 0, "thr_hit");
    inv(10'h120);
    fetch(10'h021, 0, -1, 0, 0, "inv_other");
    inv(10'h027);
    fetch(10'h021, 10, -1, 0, 0, "inv_match");
    fetch(10'h000, 0, -1, 0, 0, "inv_untouched");
    fetch(10'h040, 10, 3, 1, 10'h043, "inv_fill");
    fetch(10'h040, 10, -1, 0, 0, "inv_fill_refetch");
    req = 1'b1;
    address_in = 10'h041;
    invalidate = 1'b1;
    invalidate_address = 10'h040;
    tick();
    req = 1'b0;
    invalidate = 1'b0;
    chk("inv_hit_busy", busy, 0);
    chk("inv_hit_data", data_out, 16'h0141);
    exp_hits++;
    fetch(10'h042, 10, -1, 0, 0, "inv_hit_after");
    req = 1'b1;
    address_in = 10'h100;
    tick();
    req = 1'b0;
    tick();
    tick();
    tick();
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    chk("rst_fill_mem_req", mem_req, 0);
    chk("rst_fill_busy", busy, 0);
    chk("rst_fill_data", data_out, 0);
    chk("rst_fill_addr", mem_address, 0);
    exp_hits = 0;
    exp_miss = 0;
    fetch(10'h00A, 10, -1, 0, 0, "rst_cold");
    log_q.delete();
    fetch(10'h0C5, 15, 4, 2, 10'h0C3, "freeze");
    chk_log("freeze_addr", 10'h0C0);
    fetch(10'h0C0, 0, -1, 0, 0, "freeze_hit");
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_miss);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
